// File: rtl/fnn_pkg.sv
// Shared types and saturation helpers for the fully-connected neuron blocks.
// Activation select, neuron FSM states, config bus width and overflow detection.
package fnn_pkg;

  typedef enum logic {
    ACT_LINEAR = 1'b0,
    ACT_RELU   = 1'b1
  } act_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ACC   = 3'd1,
    ST_DRAIN = 3'd2,
    ST_BIAS  = 3'd3,
    ST_OUT   = 3'd4
  } state_e;

  localparam int CFG_W = 32;

  // Two's-complement add overflowed: operands share a sign the sum does not.
  function automatic logic add_ovf(input logic a_sign, input logic b_sign, input logic sum_sign);
    return (a_sign == b_sign) && (sum_sign != a_sign);
  endfunction

endpackage

// File: rtl/nrn_weight_ram.sv
// Single write port, single registered read port weight store.
// A write to the address being read is forwarded so the read data is never stale.
module nrn_weight_ram #(
  parameter int DEPTH = 784,
  parameter int WIDTH = 16,
  parameter int AW    = 10
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
    if (we && (wr_addr == rd_addr)) rd_data <= wr_data;
    else                            rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/neuron_mac_param.sv
// One neuron: streams NUM_WEIGHT inputs against stored weights, adds bias,
// rescales the fixed-point sum and applies the selected activation.
module neuron_mac_param
  import fnn_pkg::*;
#(
  parameter int   NUM_WEIGHT = 784,
  parameter int   DATA_W     = 16,
  parameter int   FRAC_W     = 8,
  parameter int   LAYER_NO   = 1,
  parameter int   NEURON_NO  = 0,
  parameter act_e ACT        = ACT_RELU
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_weight_valid,
  input  logic              cfg_bias_valid,
  input  logic [CFG_W-1:0]  cfg_layer,
  input  logic [CFG_W-1:0]  cfg_neuron,
  input  logic [CFG_W-1:0]  cfg_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              busy,
  output state_e            state
);

  localparam int AW = (NUM_WEIGHT > 1) ? $clog2(NUM_WEIGHT) : 1;
  localparam int PW = 2 * DATA_W;
  localparam logic [AW-1:0] LAST_IDX = AW'(NUM_WEIGHT - 1);
  localparam logic signed [PW-1:0] ACC_MAX = {1'b0, {(PW-1){1'b1}}};
  localparam logic signed [PW-1:0] ACC_MIN = {1'b1, {(PW-1){1'b0}}};
  localparam logic [DATA_W-1:0] OUT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] OUT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

  function automatic logic signed [PW-1:0] sat_add(input logic signed [PW-1:0] a,
                                                   input logic signed [PW-1:0] b);
    logic signed [PW-1:0] s;
    s = a + b;
    if (add_ovf(a[PW-1], b[PW-1], s[PW-1])) return a[PW-1] ? ACC_MIN : ACC_MAX;
    return s;
  endfunction

  state_e state_d;
  logic [AW-1:0] wr_ptr, wr_ptr_next, rd_cnt, rd_cnt_next, rd_addr;
  logic [DATA_W-1:0] w_rd, bias_q, result_sat, result;
  logic signed [PW-1:0] acc_q, prod_q, in_ext, w_ext, product, bias_ext, acc_add, acc_fin, shifted;
  logic prod_vld, accept, cfg_hit, we, fits;
  logic unused_cfg;

  assign unused_cfg = ^cfg_data[CFG_W-1:DATA_W];

  // Handshake: a beat transfers on in_valid && in_ready and on out_valid && out_ready;
  // in_ready depends only on state, out_valid/out_data are held until accepted.
  assign in_ready  = (state == ST_IDLE) || (state == ST_ACC);
  assign out_valid = (state == ST_OUT);
  assign busy      = (state != ST_IDLE);
  assign accept    = in_valid && in_ready;

  assign cfg_hit = (cfg_layer == CFG_W'(LAYER_NO)) && (cfg_neuron == CFG_W'(NEURON_NO))
                   && (state == ST_IDLE);
  assign we      = cfg_weight_valid && cfg_hit;

  assign wr_ptr_next = (wr_ptr == LAST_IDX) ? '0 : wr_ptr + AW'(1);
  assign rd_cnt_next = (rd_cnt == LAST_IDX) ? '0 : rd_cnt + AW'(1);
  // Prefetch: the RAM always presents weight[rd_cnt] during the accept cycle.
  assign rd_addr = rst ? '0 : (accept ? rd_cnt_next : rd_cnt);

  nrn_weight_ram #(
    .DEPTH (NUM_WEIGHT),
    .WIDTH (DATA_W),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .we      (we),
    .wr_addr (wr_ptr),
    .wr_data (cfg_data[DATA_W-1:0]),
    .rd_addr (rd_addr),
    .rd_data (w_rd)
  );

  always_comb begin
    state_d = state;
    case (state)
      ST_IDLE, ST_ACC: if (accept) state_d = (rd_cnt == LAST_IDX) ? ST_DRAIN : ST_ACC;
      ST_DRAIN:        state_d = ST_BIAS;
      ST_BIAS:         state_d = ST_OUT;
      ST_OUT:          if (out_ready) state_d = ST_IDLE;
      default:         state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ext   = PW'($signed(in_data));
    w_ext    = PW'($signed(w_rd));
    product  = in_ext * w_ext;
    acc_add  = sat_add(acc_q, prod_q);
    bias_ext = PW'($signed(bias_q)) <<< FRAC_W;
    acc_fin  = sat_add(acc_q, bias_ext);
    shifted  = acc_fin >>> FRAC_W;
    fits     = (&shifted[PW-1:DATA_W-1]) || ~(|shifted[PW-1:DATA_W-1]);
    result_sat = fits ? shifted[DATA_W-1:0] : (shifted[PW-1] ? OUT_MIN : OUT_MAX);
    result   = ((ACT == ACT_RELU) && result_sat[DATA_W-1]) ? '0 : result_sat;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      wr_ptr   <= '0;
      rd_cnt   <= '0;
      acc_q    <= '0;
      bias_q   <= '0;
      prod_q   <= '0;
      prod_vld <= 1'b0;
      out_data <= '0;
    end else begin
      state    <= state_d;
      prod_vld <= accept;
      if (we) wr_ptr <= wr_ptr_next;
      if (cfg_bias_valid && cfg_hit) bias_q <= cfg_data[DATA_W-1:0];
      if (accept) begin
        rd_cnt <= rd_cnt_next;
        prod_q <= product;
      end
      if ((state == ST_IDLE) && accept) acc_q <= '0;
      else if (prod_vld)                acc_q <= acc_add;
      else if (state == ST_BIAS)        acc_q <= acc_fin;
      if (state == ST_BIAS) out_data <= result;
    end
  end

endmodule

// File: tb/tb_neuron_mac_param.sv
// Directed bench for a 4-input neuron; a ReLU and a linear instance share all stimulus
// so each sample checks both activations against hand-computed results.
module tb_neuron_mac_param;
  import fnn_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic cfg_weight_valid, cfg_bias_valid;
  logic [31:0] cfg_layer, cfg_neuron, cfg_data;
  logic in_valid, out_ready;
  logic [15:0] in_data;

  logic r_in_ready, r_out_valid, r_busy;
  logic [15:0] r_out_data;
  state_e r_state;
  logic l_in_ready, l_out_valid, l_busy;
  logic [15:0] l_out_data;
  state_e l_state;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  neuron_mac_param #(.NUM_WEIGHT(4), .DATA_W(16), .FRAC_W(8), .LAYER_NO(1), .NEURON_NO(0),
                     .ACT(ACT_RELU)) u_relu (
    .clk(clk), .rst(rst), .cfg_weight_valid(cfg_weight_valid), .cfg_bias_valid(cfg_bias_valid),
    .cfg_layer(cfg_layer), .cfg_neuron(cfg_neuron), .cfg_data(cfg_data),
    .in_valid(in_valid), .in_ready(r_in_ready), .in_data(in_data),
    .out_valid(r_out_valid), .out_ready(out_ready), .out_data(r_out_data),
    .busy(r_busy), .state(r_state));

  neuron_mac_param #(.NUM_WEIGHT(4), .DATA_W(16), .FRAC_W(8), .LAYER_NO(1), .NEURON_NO(0),
                     .ACT(ACT_LINEAR)) u_lin (
    .clk(clk), .rst(rst), .cfg_weight_valid(cfg_weight_valid), .cfg_bias_valid(cfg_bias_valid),
    .cfg_layer(cfg_layer), .cfg_neuron(cfg_neuron), .cfg_data(cfg_data),
    .in_valid(in_valid), .in_ready(l_in_ready), .in_data(in_data),
    .out_valid(l_out_valid), .out_ready(out_ready), .out_data(l_out_data),
    .busy(l_busy), .state(l_state));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cfg_w(input logic [15:0] d, input logic [31:0] layer, input logic [31:0] neuron);
    cfg_layer = layer; cfg_neuron = neuron; cfg_data = {16'h0000, d};
    cfg_weight_valid = 1'b1;
    @(posedge clk); #1;
    cfg_weight_valid = 1'b0;
  endtask

  task automatic cfg_b(input logic [15:0] d);
    cfg_layer = 32'd1; cfg_neuron = 32'd0; cfg_data = {16'h0000, d};
    cfg_bias_valid = 1'b1;
    @(posedge clk); #1;
    cfg_bias_valid = 1'b0;
  endtask

  task automatic send(input logic [15:0] d, input bit gap);
    chk("in_ready_at_send", r_in_ready, 1'b1);
    in_valid = 1'b1; in_data = d;
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (gap) begin @(posedge clk); #1; end
  endtask

  task automatic send4(input logic [15:0] d);
    for (int i = 0; i < 4; i++) send(d, 1'b0);
  endtask

  // Called right after the last input is accepted; expects out_valid on the third cycle.
  task automatic wait_result(input string tag, input logic [15:0] exp_relu, input logic [15:0] exp_lin);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n < 3) chk({tag, "_in_ready_drain"}, r_in_ready, 1'b0);
    end while (!r_out_valid && n < 8);
    chk({tag, "_latency"}, n, 3);
    chk({tag, "_relu_data"}, r_out_data, exp_relu);
    chk({tag, "_lin_valid"}, l_out_valid, 1'b1);
    chk({tag, "_lin_data"}, l_out_data, exp_lin);
    if (out_ready) begin @(posedge clk); #1; end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] vec [4];
    rst = 1'b1; cfg_weight_valid = 1'b0; cfg_bias_valid = 1'b0;
    cfg_layer = '0; cfg_neuron = '0; cfg_data = '0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", r_out_valid, 1'b0);
    chk("rst_out_data", r_out_data, 16'h0000);
    chk("rst_busy", r_busy, 1'b0);
    chk("rst_in_ready", r_in_ready, 1'b1);
    chk("rst_state", r_state, ST_IDLE);
    chk("rst_lin_out_valid", l_out_valid, 1'b0);

    // Unit weights and inputs plus half bias.
    for (int i = 0; i < 4; i++) cfg_w(16'h0100, 32'd1, 32'd0);
    cfg_b(16'h0080);
    send4(16'h0100);
    wait_result("unit", 16'h0480, 16'h0480);
    chk("idle_after_out", r_state, ST_IDLE);

    // Negative weights with gaps in the input stream.
    for (int i = 0; i < 4; i++) cfg_w(16'hFF00, 32'd1, 32'd0);
    cfg_b(16'h0000);
    for (int i = 0; i < 4; i++) send(16'h0100, i < 3);
    wait_result("neg", 16'h0000, 16'hFC00);

    // Accumulator saturates at the 32-bit maximum, then the output at 0x7FFF.
    for (int i = 0; i < 4; i++) cfg_w(16'h7FFF, 32'd1, 32'd0);
    send4(16'h7FFF);
    wait_result("sat", 16'h7FFF, 16'h7FFF);

    // Output held under backpressure; config strobes during the hold must be dropped.
    for (int i = 0; i < 4; i++) cfg_w(16'h0100, 32'd1, 32'd0);
    cfg_b(16'h0080);
    out_ready = 1'b0;
    send4(16'h0100);
    wait_result("hold", 16'h0480, 16'h0480);
    cfg_layer = 32'd1; cfg_neuron = 32'd0; cfg_data = 32'h0000_0200;
    cfg_weight_valid = 1'b1; cfg_bias_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("hold_out_valid", r_out_valid, 1'b1);
      chk("hold_out_data", r_out_data, 16'h0480);
      chk("hold_in_ready", r_in_ready, 1'b0);
    end
    cfg_weight_valid = 1'b0; cfg_bias_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("hold_release_valid", r_out_valid, 1'b0);
    chk("hold_release_busy", r_busy, 1'b0);
    send4(16'h0100);
    wait_result("after_hold", 16'h0480, 16'h0480);

    // Reset mid-sample: weights kept, bias and partial sum cleared.
    send(16'h0100, 1'b0);
    send(16'h0100, 1'b0);
    chk("mid_busy", r_busy, 1'b1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_state", r_state, ST_IDLE);
    chk("abort_out_data", r_out_data, 16'h0000);
    chk("abort_in_ready", r_in_ready, 1'b1);
    send4(16'h0100);
    wait_result("abort_nobias", 16'h0400, 16'h0400);
    cfg_b(16'h0080);
    send4(16'h0100);
    wait_result("abort_full", 16'h0480, 16'h0480);

    // Mismatched address writes ignored; the fifth matching write wraps to weight[0].
    cfg_w(16'h0300, 32'd1, 32'd1);
    cfg_w(16'h0300, 32'd1, 32'd1);
    cfg_w(16'h0300, 32'd2, 32'd0);
    send4(16'h0100);
    wait_result("mismatch", 16'h0480, 16'h0480);
    for (int i = 0; i < 4; i++) cfg_w(16'h0100, 32'd1, 32'd0);
    cfg_w(16'h0200, 32'd1, 32'd0);
    vec[0] = 16'h0300; vec[1] = 16'h0000; vec[2] = 16'h0000; vec[3] = 16'h0000;
    for (int i = 0; i < 4; i++) send(vec[i], 1'b0);
    wait_result("wrap_w0", 16'h0680, 16'h0680);
    vec[0] = 16'h0000; vec[1] = 16'hFF00; vec[2] = 16'h0000; vec[3] = 16'h0200;
    for (int i = 0; i < 4; i++) send(vec[i], 1'b0);
    wait_result("wrap_mixed", 16'h0180, 16'h0180);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/neuron_mac_param.md
NEURON_MAC_PARAM -- requirements
Module: neuron_mac_param

Interface
REQ-001 SHALL have parameter NUM_WEIGHT, default 784, number of inputs/weights per output sample.
REQ-002 SHALL have parameter DATA_W, default 16, signed two's-complement width of inputs, weights, bias and output.
REQ-003 SHALL have parameter FRAC_W, default 8, fractional bits of DATA_W fixed-point values.
REQ-004 SHALL have parameters LAYER_NO, default 1, and NEURON_NO, default 0, the config address of this neuron.
REQ-005 SHALL have parameter ACT, default ACT_RELU, activation select from the package (ACT_LINEAR | ACT_RELU).
REQ-006 SHALL have ports: clk input 1, clock; rst input 1, reset (synchronous, active-high).
REQ-007 SHALL have ports: cfg_weight_valid input 1 and cfg_bias_valid input 1, config write strobes.
REQ-008 SHALL have ports: cfg_layer input 32 and cfg_neuron input 32, config target; cfg_data input 32, config value (low DATA_W bits used).
REQ-009 SHALL have ports: in_valid input 1, in_ready output 1, in_data input DATA_W, input stream.
REQ-010 SHALL have ports: out_valid output 1, out_ready input 1, out_data output DATA_W, result stream.
REQ-011 SHALL have port busy output 1, high whenever state is not IDLE.

Function
REQ-012 SHALL write cfg_data[DATA_W-1:0] into weight RAM when cfg_weight_valid, cfg_layer==LAYER_NO, cfg_neuron==NEURON_NO and state==IDLE; the write pointer increments and wraps NUM_WEIGHT-1 -> 0.
REQ-013 SHALL load bias register from cfg_data[DATA_W-1:0] on a matching cfg_bias_valid in IDLE; config strobes outside IDLE are dropped.
REQ-014 SHALL run FSM IDLE -> ACC (first in_valid&&in_ready) -> DRAIN (NUM_WEIGHT-th input accepted) -> BIAS (last product accumulated) -> OUT -> IDLE (out_valid&&out_ready).
REQ-015 SHALL drive in_ready=1 in IDLE and in ACC, 0 in DRAIN, BIAS, OUT; inputs transfer on in_valid&&in_ready; gaps in in_valid are allowed.
REQ-016 SHALL read weight[k] for input k in the accept cycle, register product in_data*weight (2*DATA_W signed) one cycle later, accumulate the next cycle.
REQ-017 SHALL keep a 2*DATA_W signed accumulator, cleared on entry to ACC, adding products with saturation to max/min 2*DATA_W value on overflow.
REQ-018 SHALL in BIAS add bias sign-extended and shifted left FRAC_W bits, with the same saturation.
REQ-019 SHALL form result = accumulator arithmetically shifted right FRAC_W, saturated to DATA_W range, then ReLU (negatives -> 0) if ACT==ACT_RELU.
REQ-020 SHALL in OUT hold out_valid=1 and out_data stable until out_ready; result latency is 3 cycles after the last input accepted when out_ready=1.
REQ-021 SHALL accept a new sample's first input in the cycle after out handshake (IDLE), never in the same cycle.
REQ-022 SHALL accept NUM_WEIGHT=1 (ACC skipped: IDLE -> DRAIN directly).

Reset
REQ-023 SHALL on rst: state=IDLE, write pointer=0, read counter=0, accumulator=0, bias=0, out_valid=0, out_data=0, busy=0, in_ready=1 after release.
REQ-024 SHALL treat rst mid-sample as abort: partial sum discarded, weight RAM contents retained.

Structure
REQ-025 SHALL place ACT_LINEAR/ACT_RELU enum, state enum and sat helper constants in shared package fnn_pkg.
REQ-026 SHALL instantiate one sub-module nrn_weight_ram (1 write port, 1 registered read port, depth NUM_WEIGHT, width DATA_W).

Verification (NUM_WEIGHT=4, DATA_W=16, FRAC_W=8)
REQ-027 SHALL test: weights 0x0100 x4, bias 0x0080, inputs 0x0100 x4, ReLU -> out_data 0x0480, out_valid 3 cycles after 4th input.
REQ-028 SHALL test: weights 0xFF00 (-1.0), inputs 0x0100, bias 0, ACT_RELU -> 0x0000; ACT_LINEAR -> 0xFC00.
REQ-029 SHALL test: weights and inputs 0x7FFF x4 -> out_data 0x7FFF (saturation), no wrap.
REQ-030 SHALL test: out_ready low 10 cycles -> out_valid, out_data stable, in_ready=0; cfg writes during hold dropped.
REQ-031 SHALL test: rst after 2 inputs, then full sample of REQ-027 -> 0x0480 (no stale partial sum).
REQ-032 SHALL test: cfg writes with mismatched cfg_neuron -> weights unchanged; 5th matching write overwrites weight[0].
